monitor_contador_vaivem: RTL and testbench
==========================================

Name: monitor_contador_vaivem

Overview:
- Downstream checker for the 4-bit up/down ("vai-e-vem") counter stage.
- The counter sequence after reset is 0,1,…,15,15,14,…,1,0,0,1,… (the extreme value is held for one extra cycle at each turn-around).
- This block samples the counter output and tracks the current direction.
- It counts completed full cycles and raises a sticky error on any illegal step, so the counter can be checked in-system.

Parameters:
- LARGURA, 4, width of the monitored counter value; MAX = 2^LARGURA-1.
- LARGURA_VOLTAS, 8, width of the completed-cycle counter.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- valor  input  LARGURA  counter value being monitored.
- valido  input  1  sample enable; valor is evaluated only on edges where valido=1.
- sentido  output  1  tracked direction: 0 = up, 1 = down.
- sincronizado  output  1  1 when the monitor is locked to the sequence.
- voltas  output  LARGURA_VOLTAS  number of completed cycles (0→MAX→0→0).
- erro  output  1  sticky illegal-step flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - State INICIO, internal prev=0.
  - Outputs: sentido=0, sincronizado=0, voltas=0, erro=0.
  - Reset takes effect immediately, including mid-sequence. After release, the first rising edge is normal.
- All outputs are registered; each reflects the sample taken on the previous valid edge (latency 1 cycle).
- valido=0: no state, prev, voltas or erro change. Gaps of any length are transparent.
- On every valid sample, prev ← valor.
- INICIO:
  - valor==0 → SUBINDO.
  - Any other value → stay in INICIO; no error (still resynchronising).
- SUBINDO: expects valor==prev+1.
  - Match with valor==MAX → TOPO.
  - Match otherwise → stay.
  - Mismatch → error handling.
- TOPO: expects valor==MAX (the hold cycle).
  - Match → DESCENDO.
  - Mismatch → error handling.
- DESCENDO: expects valor==prev-1.
  - Match with valor==0 → BASE.
  - Match otherwise → stay.
  - Mismatch → error handling.
- BASE: expects valor==0 (the hold cycle).
  - Match → SUBINDO and voltas increments.
  - Mismatch → error handling.
- Error handling: erro ← 1 and next state INICIO. The offending sample is not re-evaluated as a resync candidate: even if valor==0 on the error edge, lock needs a further 0 sample.
- erro is sticky; only reset clears it.
- sentido=1 in TOPO and DESCENDO, 0 in all other states.
- sincronizado=1 in every state except INICIO.
- Arithmetic:
  - prev±1 is computed in LARGURA bits with no wrap acceptance; 15→0 and 0→15 are illegal steps.
  - voltas is LARGURA_VOLTAS bits; default wraps modulo 2^LARGURA_VOLTAS.
- Steady-state lock: one full cycle is 32 valid samples for LARGURA=4, i.e. 2·(MAX+1).

Optional Feature:
- Macro: MONITOR_VOLTAS_SATURA_EN.
- Defined: voltas saturates at 2^LARGURA_VOLTAS-1 and holds there until reset.
- Not defined: voltas wraps to 0 after 2^LARGURA_VOLTAS-1.
- No other behaviour changes.

Test Plan:
- Reset, then drive the true counter sequence with valido=1 for 33 cycles (0..15,15..0,0) → after the last edge: voltas=1, sentido=0, sincronizado=1, erro=0; sentido=1 from the second 15 through the first 0 of the descent.
- Drive 0,1,2,3,5 → on the edge after 5: erro=1, sincronizado=0. Then 0,1 → sincronizado=1 again, erro stays 1.
- Drive 0..15 then 14 (no hold at top) → erro=1, state INICIO.
- Correct sequence with valido toggled 1,0,0,1,… and valor held during gaps → identical voltas and sentido trace to the gap-free run, erro=0.
- Assert reset=0 asynchronously mid-descent (valor=9) between edges → outputs clear immediately. After release, sequence restarting at 0 → sincronizado=1 on the next valid edge.
- LARGURA_VOLTAS=2, run 5 full cycles → voltas=1 (wrap) without the macro; voltas=3 with MONITOR_VOLTAS_SATURA_EN.

Source files
------------

// File: rtl/monitor_contador_vaivem.sv
// Checker for the up/down (vai-e-vem) counter stage: tracks direction,
// counts full cycles, flags illegal steps. Macro: MONITOR_VOLTAS_SATURA_EN.
module monitor_contador_vaivem #(
  parameter int LARGURA        = 4,
  parameter int LARGURA_VOLTAS = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LARGURA-1:0]        valor,
  input  logic                      valido,
  output logic                      sentido,
  output logic                      sincronizado,
  output logic [LARGURA_VOLTAS-1:0] voltas,
  output logic                      erro
);

  localparam logic [2:0] INICIO   = 3'd0;
  localparam logic [2:0] SUBINDO  = 3'd1;
  localparam logic [2:0] TOPO     = 3'd2;
  localparam logic [2:0] DESCENDO = 3'd3;
  localparam logic [2:0] BASE     = 3'd4;

  localparam logic [LARGURA-1:0] MAX  = '1;
  localparam logic [LARGURA-1:0] ZERO = '0;
  localparam logic [LARGURA-1:0] UM   = LARGURA'(1);

  localparam logic [LARGURA_VOLTAS-1:0] V_UM  =
    LARGURA_VOLTAS'(1);
  localparam logic [LARGURA_VOLTAS-1:0] V_MAX = '1;

  logic [2:0]                estado_q, estado_d;
  logic [LARGURA-1:0]        prev_q, prev_d;
  logic [LARGURA_VOLTAS-1:0] voltas_q, voltas_d;
  logic                      erro_q, erro_d;
  logic                      sentido_q, sentido_d;
  logic                      sinc_q, sinc_d;

  logic [LARGURA-1:0]        prev_mais;
  logic [LARGURA-1:0]        prev_menos;
  logic                      falha;
  logic                      conta;

  // Expected neighbours of the previous sample, no wrap-around.
  always_comb begin
    prev_mais  = prev_q + UM;
    prev_menos = prev_q - UM;
  end

  // Sequence tracker: judges each valid sample against the state.
  always_comb begin
    estado_d = estado_q;
    prev_d   = prev_q;
    falha    = 1'b0;
    conta    = 1'b0;
    if (valido) begin
      prev_d = valor;
      case (estado_q)
        INICIO: begin
          if (valor == ZERO) estado_d = SUBINDO;
        end
        SUBINDO: begin
          if (prev_q == MAX || valor != prev_mais)
            falha = 1'b1;
          else if (valor == MAX)
            estado_d = TOPO;
        end
        TOPO: begin
          if (valor == MAX) estado_d = DESCENDO;
          else              falha    = 1'b1;
        end
        DESCENDO: begin
          if (prev_q == ZERO || valor != prev_menos)
            falha = 1'b1;
          else if (valor == ZERO)
            estado_d = BASE;
        end
        BASE: begin
          if (valor == ZERO) begin
            estado_d = SUBINDO;
            conta    = 1'b1;
          end else begin
            falha = 1'b1;
          end
        end
        default: begin
          estado_d = INICIO;
        end
      endcase
      // The offending sample never doubles as a resync zero.
      if (falha) estado_d = INICIO;
    end
  end

  // Sticky error flag.
  always_comb begin
    erro_d = erro_q | falha;
  end

  // Completed-cycle counter, wrapping or saturating.
  always_comb begin
    voltas_d = voltas_q;
    if (conta) begin
`ifdef MONITOR_VOLTAS_SATURA_EN
      if (voltas_q != V_MAX) voltas_d = voltas_q + V_UM;
`else
      voltas_d = voltas_q + V_UM;
`endif
    end
  end

  // Status outputs decoded from the next state so they leave a flop.
  always_comb begin
    sentido_d = (estado_d == TOPO) || (estado_d == DESCENDO);
    sinc_d    = (estado_d != INICIO);
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIO;
      prev_q    <= ZERO;
      voltas_q  <= '0;
      erro_q    <= 1'b0;
      sentido_q <= 1'b0;
      sinc_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      prev_q    <= prev_d;
      voltas_q  <= voltas_d;
      erro_q    <= erro_d;
      sentido_q <= sentido_d;
      sinc_q    <= sinc_d;
    end
  end

  assign sentido      = sentido_q;
  assign sincronizado = sinc_q;
  assign voltas       = voltas_q;
  assign erro         = erro_q;

  // Illegal encodings cannot be reached from reset.
  unused_chk_a: assert property (
    @(posedge clock) disable iff (!reset) estado_q <= BASE
  );

endmodule

// File: tb/tb_monitor_contador_vaivem.sv
// Directed bench for monitor_contador_vaivem: vector table plus
// hand-written corner sequences (errors, gaps, async reset, wrap).
module tb_monitor_contador_vaivem;

  logic       clk;
  logic       reset;
  logic [3:0] valor;
  logic       valido;
  logic       sentido;
  logic       sinc;
  logic [7:0] voltas;
  logic       erro;

  logic       reset2;
  logic [3:0] valor2;
  logic       valido2;
  logic       sentido2;
  logic       sinc2;
  logic [1:0] voltas2;
  logic       erro2;

  int n_cmp = 0;
  int n_mis = 0;

  monitor_contador_vaivem #(.LARGURA(4), .LARGURA_VOLTAS(8)) u_dut (
    .clock(clk), .reset(reset), .valor(valor), .valido(valido),
    .sentido(sentido), .sincronizado(sinc), .voltas(voltas),
    .erro(erro)
  );

  monitor_contador_vaivem #(.LARGURA(4), .LARGURA_VOLTAS(2)) u_dut2 (
    .clock(clk), .reset(reset2), .valor(valor2), .valido(valido2),
    .sentido(sentido2), .sincronizado(sinc2), .voltas(voltas2),
    .erro(erro2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [3:0] val;
    logic       e_sent;
    logic       e_sinc;
    logic [7:0] e_volt;
    logic       e_erro;
  } vec_t;

  vec_t tab[33];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int s, input int y,
                         input int v, input int e);
    chk({tag, ".sentido"}, int'(sentido), s);
    chk({tag, ".sinc"}, int'(sinc), y);
    chk({tag, ".voltas"}, int'(voltas), v);
    chk({tag, ".erro"}, int'(erro), e);
  endtask

  task automatic samp(input logic v, input logic [3:0] d);
    @(negedge clk);
    valido = v;
    valor  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset  = 1'b0;
    valido = 1'b0;
    valor  = 4'd0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int exp_w;
    reset   = 1'b0;
    valido  = 1'b0;
    valor   = 4'd0;
    reset2  = 1'b0;
    valido2 = 1'b0;
    valor2  = 4'd0;

    for (int i = 0; i < 16; i++)
      tab[i] = '{1'b1, 4'(i), (i == 15), 1'b1, 8'd0, 1'b0};
    for (int j = 0; j < 16; j++)
      tab[16+j] = '{1'b1, 4'(15 - j), (j < 15), 1'b1, 8'd0, 1'b0};
    tab[32] = '{1'b1, 4'd0, 1'b0, 1'b1, 8'd1, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // full gap-free cycle
    for (int k = 0; k < 33; k++) begin
      samp(tab[k].vld, tab[k].val);
      chk_all($sformatf("seq%0d", k), int'(tab[k].e_sent),
              int'(tab[k].e_sinc), int'(tab[k].e_volt),
              int'(tab[k].e_erro));
    end

    // bad step 3 -> 5, then relock with 0,1
    do_reset();
    samp(1'b1, 4'd7);
    chk_all("inicio_nz", 0, 0, 0, 0);
    samp(1'b1, 4'd0);
    samp(1'b1, 4'd1);
    samp(1'b1, 4'd2);
    samp(1'b1, 4'd3);
    chk_all("pre_err", 0, 1, 0, 0);
    samp(1'b1, 4'd5);
    chk_all("err35", 0, 0, 0, 1);
    samp(1'b1, 4'd0);
    chk_all("relock0", 0, 1, 0, 1);
    samp(1'b1, 4'd1);
    chk_all("relock1", 0, 1, 0, 1);

    // 0 -> 15 is not a legal wrap
    do_reset();
    samp(1'b1, 4'd0);
    samp(1'b1, 4'd15);
    chk_all("wrap0_15", 0, 0, 0, 1);

    // error sample of 0 is not itself a resync point
    do_reset();
    samp(1'b1, 4'd0);
    samp(1'b1, 4'd1);
    samp(1'b1, 4'd0);
    chk_all("err_on0", 0, 0, 0, 1);
    samp(1'b1, 4'd0);
    chk_all("after_err0", 0, 1, 0, 1);

    // no hold at top
    do_reset();
    for (int k = 0; k < 16; k++) samp(1'b1, 4'(k));
    chk_all("top_reach", 1, 1, 0, 0);
    samp(1'b1, 4'd14);
    chk_all("no_hold", 0, 0, 0, 1);

    // gaps: valid, idle, idle, with valor held
    do_reset();
    for (int k = 0; k < 33; k++) begin
      samp(1'b1, tab[k].val);
      chk_all($sformatf("gap%0d", k), int'(tab[k].e_sent),
              int'(tab[k].e_sinc), int'(tab[k].e_volt), 0);
      samp(1'b0, tab[k].val);
      samp(1'b0, tab[k].val);
      chk_all($sformatf("gapidle%0d", k), int'(tab[k].e_sent),
              int'(tab[k].e_sinc), int'(tab[k].e_volt), 0);
    end

    // async reset mid-descent at valor 9
    do_reset();
    for (int k = 0; k <= 22; k++) samp(1'b1, tab[k].val);
    chk_all("pre_arst", 1, 1, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_all("arst", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    samp(1'b1, 4'd0);
    chk_all("post_arst", 0, 1, 0, 0);

    // narrow cycle counter: five full cycles
    @(negedge clk);
    reset2 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        valido2 = 1'b1;
        valor2  = tab[k].val;
      end
    end
    @(negedge clk);
    valor2 = 4'd0;
    @(posedge clk);
    #1;
`ifdef MONITOR_VOLTAS_SATURA_EN
    exp_w = 3;
`else
    exp_w = 1;
`endif
    chk("voltas2", int'(voltas2), exp_w);
    chk("erro2", int'(erro2), 0);
    chk("sinc2", int'(sinc2), 1);
    chk("sentido2", int'(sentido2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
